// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage with one-outstanding imem request and redirect handling
module if_fetch_unit #(
  parameter int                 I_SIZE   = 32,
  parameter int                 AD_SIZE  = 32,
  parameter logic [AD_SIZE-1:0] RESET_PC = '0,
  parameter logic [AD_SIZE-1:0] PC_INC   = AD_SIZE'(4)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PC_write,
  input  logic               redirect,
  input  logic [AD_SIZE-1:0] redirect_pc,
  output logic               imem_req,
  output logic [AD_SIZE-1:0] imem_addr,
  input  logic               imem_rvalid,
  input  logic [I_SIZE-1:0]  imem_rdata,
  output logic [I_SIZE-1:0]  im_Instruction,
  output logic [AD_SIZE-1:0] pc,
  output logic               if_valid,
  output logic               IF_flush
);

  // FETCH issues, WAIT awaits the response, HOLD keeps a stalled word,
  // DROP swallows a response that belongs to a squashed path.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [AD_SIZE-1:0] pc_reg;
  logic [AD_SIZE-1:0] pc_next;
  logic [I_SIZE-1:0]  buf_instr;
  logic [I_SIZE-1:0]  buf_next;
  logic               present_mem;
  logic               present_buf;

  // State, PC and stall buffer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_FETCH;
      pc_reg    <= RESET_PC;
      buf_instr <= '0;
    end else begin
      state     <= state_next;
      pc_reg    <= pc_next;
      buf_instr <= buf_next;
    end
  end

  // Next-state logic; a redirect always overrides the hazard unit's PC_write.
  always_comb begin
    state_next  = state;
    pc_next     = pc_reg;
    buf_next    = buf_instr;
    present_mem = 1'b0;
    present_buf = 1'b0;

    case (state)
      S_FETCH: begin
        // The request goes out this cycle regardless, so a redirect here
        // leaves a wrong-path response in flight that must be dropped.
        state_next = redirect ? S_DROP : S_WAIT;
      end

      S_WAIT: begin
        if (imem_rvalid) begin
          if (redirect) begin
            state_next = S_FETCH;
          end else begin
            present_mem = 1'b1;
            if (PC_write) begin
              pc_next    = pc_reg + PC_INC;
              state_next = S_FETCH;
            end else begin
              buf_next   = imem_rdata;
              state_next = S_HOLD;
            end
          end
        end else if (redirect) begin
          state_next = S_DROP;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          state_next = S_FETCH;
        end else begin
          present_buf = 1'b1;
          if (PC_write) begin
            pc_next    = pc_reg + PC_INC;
            state_next = S_FETCH;
          end
        end
      end

      S_DROP: begin
        if (imem_rvalid) begin
          state_next = S_FETCH;
        end
      end

      default: begin
        state_next = S_FETCH;
      end
    endcase

    if (redirect) begin
      pc_next = redirect_pc;
    end
  end

  // Outputs toward imem and IF/ID; everything is forced quiet while in reset.
  always_comb begin
    imem_req       = rst && (state == S_FETCH);
    imem_addr      = pc_reg;
    pc             = pc_reg;
    if_valid       = rst && (present_mem || present_buf);
    IF_flush       = rst && redirect;
    im_Instruction = '0;
    if (rst && present_mem) begin
      im_Instruction = imem_rdata;
    end else if (rst && present_buf) begin
      im_Instruction = buf_instr;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed and randomized checks of if_fetch_unit against a transaction-level model
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        PC_write;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] im_Instruction;
  logic [31:0] pc;
  logic        if_valid;
  logic        IF_flush;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // memory environment: one in-flight request with a countdown
  logic        m_busy = 1'b0;
  int          m_cnt  = 0;
  logic [31:0] m_addr = '0;
  int          lat    = 1;

  // reference model: fetch pointer, held word, whether in-flight data is wanted
  logic [31:0] mpc    = '0;
  logic        held   = 1'b0;
  logic [31:0] held_d = '0;
  logic        wanted = 1'b1;

  // observation logs
  logic [31:0] rq_addr[$];
  int          rq_cyc[$];
  int          v_log[$];
  int          flush_cnt = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .I_SIZE(32), .AD_SIZE(32), .RESET_PC(32'd0), .PC_INC(32'd4)
  ) dut (
    .clk(clk), .rst(rst), .PC_write(PC_write), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .im_Instruction(im_Instruction), .pc(pc), .if_valid(if_valid),
    .IF_flush(IF_flush)
  );

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // one clock cycle: drive at negedge, check outputs, advance model at posedge
  task automatic step(input logic pcw, input logic redir, input logic [31:0] tgt, input logic rstn);
    logic        resp, e_req, e_valid, e_flush, d_req;
    logic [31:0] e_instr, e_pc, d_addr;
    @(negedge clk);
    rst         = rstn;
    PC_write    = pcw;
    redirect    = redir;
    redirect_pc = tgt;
    resp        = m_busy && (m_cnt == 1);
    imem_rvalid = resp;
    imem_rdata  = resp ? mem_data(m_addr) : $urandom;
    #1;
    if (!rstn) begin
      e_req = 1'b0; e_valid = 1'b0; e_flush = 1'b0; e_instr = '0;
    end else begin
      e_req   = !m_busy && !held;
      e_flush = redir;
      e_valid = !redir && (held || (resp && wanted));
      e_instr = !e_valid ? 32'd0 : (held ? held_d : mem_data(m_addr));
    end
    e_pc = mpc;
    chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
    chk("if_valid", {31'd0, if_valid}, {31'd0, e_valid});
    chk("IF_flush", {31'd0, IF_flush}, {31'd0, e_flush});
    chk("im_Instruction", im_Instruction, e_instr);
    chk("pc", pc, e_pc);
    if (e_req) chk("imem_addr", imem_addr, e_pc);
    d_req  = imem_req;
    d_addr = imem_addr;
    if (rstn && if_valid) v_log.push_back(cyc);
    if (rstn && d_req) begin
      rq_addr.push_back(d_addr);
      rq_cyc.push_back(cyc);
    end
    if (IF_flush) flush_cnt++;
    @(posedge clk);
    if (!rstn) begin
      mpc = 32'd0; held = 1'b0; m_busy = 1'b0; wanted = 1'b1;
    end else begin
      if (resp) m_busy = 1'b0;
      else if (m_busy) m_cnt--;
      if (d_req) begin
        m_busy = 1'b1; m_cnt = lat; m_addr = d_addr; wanted = 1'b1;
      end
      if (redir) begin
        mpc = tgt; held = 1'b0; wanted = 1'b0;
      end else if (e_valid && pcw) begin
        mpc = mpc + 32'd4; held = 1'b0;
      end else if (e_valid && !held) begin
        held = 1'b1; held_d = e_instr;
      end
    end
    cyc++;
  endtask

  task automatic clear_logs();
    rq_addr.delete();
    rq_cyc.delete();
    v_log.delete();
    flush_cnt = 0;
  endtask

  initial begin
    int          base;
    int          n;
    logic        r_pcw, r_redir, r_rstn;
    logic [31:0] r_tgt;

    rst = 1'b0; PC_write = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    @(posedge clk);

    // reset state
    step(1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    chk("reset_pc", pc, 32'd0);
    chk("reset_if_valid", {31'd0, if_valid}, 32'd0);

    // T1: L=1, request every second cycle, valid in between
    lat = 1;
    clear_logs();
    base = cyc;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
    chk("t1_req_count", rq_addr.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t1_req_addr", rq_addr[i], 32'(4 * i));
      chk("t1_req_cycle", rq_cyc[i] - base, 32'(2 * i));
      chk("t1_valid_cycle", v_log[i] - base, 32'(2 * i + 1));
    end

    // T2: stall at address 4 for three cycles, then release
    step(1'b1, 1'b0, 32'd0, 1'b0);
    clear_logs();
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("t2_hold_instr", im_Instruction, mem_data(32'd4));
    chk("t2_hold_pc", pc, 32'd4);
    chk("t2_no_req_in_hold", rq_addr.size(), 32'd2);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    lat = 3;
    step(1'b1, 1'b0, 32'd0, 1'b1);
    n = rq_addr.size();
    chk("t2_next_req", rq_addr[n-1], 32'd8);

    // T3: L=3, redirect to 0x100 one cycle after the request to 8
    clear_logs();
    step(1'b1, 1'b1, 32'h100, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    lat = 1;
    step(1'b1, 1'b0, 32'd0, 1'b1);
    chk("t3_flush_cycles", flush_cnt, 32'd1);
    chk("t3_stale_dropped", v_log.size(), 32'd0);
    chk("t3_req_target", rq_addr[0], 32'h100);

    // T4: redirect to 0x40 while stalled in HOLD
    clear_logs();
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b1, 32'h40, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("t4_req_target", rq_addr[0], 32'h40);

    // T5: redirect in the same cycle the response arrives
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    clear_logs();
    base = cyc;
    step(1'b1, 1'b1, 32'h200, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    chk("t5_dropped", v_log.size(), 32'd0);
    chk("t5_req_target", rq_addr[0], 32'h200);
    chk("t5_req_cycle", rq_cyc[0] - base, 32'd1);

    // T6: reset asserted while waiting on a response
    step(1'b1, 1'b0, 32'd0, 1'b1);
    lat = 3;
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    clear_logs();
    step(1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    chk("t6_quiet_req", rq_addr.size(), 32'd0);
    chk("t6_quiet_valid", v_log.size(), 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    chk("t6_req_reset_pc", rq_addr[0], 32'd0);

    // T7: PC wraps from the top of the address space
    lat = 1;
    clear_logs();
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
    n = rq_addr.size();
    chk("t7_req_top", rq_addr[n-2], 32'hFFFF_FFFC);
    chk("t7_req_wrap", rq_addr[n-1], 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      lat     = $urandom_range(1, 4);
      r_rstn  = ($urandom_range(0, 99) != 0);
      r_redir = ($urandom_range(0, 99) < 8);
      r_pcw   = ($urandom_range(0, 99) < 70);
      r_tgt   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      step(r_pcw, r_redir, r_tgt, r_rstn);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
